matrix_transposer: RTL and testbench

Registered fixed-point matrix transposer: captures a row×col matrix of signed IL.FL words on a request and presents its col×row transpose on a registered output. A 2-bit state handshake tells the consumer when the result is valid. The consumer releases the block with `output_taken`. It sits between matrix-producing and matrix-consuming datapath stages of the accelerator and performs no arithmetic.

---
 rtl/matrix_transposer.sv | 89 ++++++++
 tb/tb_matrix_transposer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_transposer.sv
// Purpose : registered transposer for a row x col matrix of signed IL.FL words.
// Latency : request sampled at edge N -> TRANSPOSE after N, DONE with valid out after N+1.
// Backpressure: holds DONE and a stable out until output_taken; requests are not
//               accepted outside IDLE and are not queued.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - asynchronous active-low reset
//   input_ready  - request: capture in (sampled in IDLE only)
//   output_taken - consumer has taken out (acted on in DONE only)
//   in           - input matrix, element [i][j] at bits ((i*col+j)*W) +: W
//   state        - 00 IDLE, 01 TRANSPOSE, 10 DONE
//   out          - transposed matrix, element [j][i] at bits ((j*row+i)*W) +: W
module matrix_transposer #(
  parameter int IL  = 4,
  parameter int FL  = 16,
  parameter int row = 8,
  parameter int col = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      input_ready,
  input  logic                      output_taken,
  input  logic [row*col*(IL+FL)-1:0] in,
  output logic [1:0]                state,
  output logic [col*row*(IL+FL)-1:0] out
);

  localparam int W = IL + FL;
  localparam int N = row * col * W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_TRANS = 2'b01,
    S_DONE  = 2'b10,
    S_BAD   = 2'b11
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   buf_q, buf_d;
  logic [N-1:0]   out_q, out_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (input_ready) begin
          buf_d   = in;
          state_d = S_TRANS;
        end
      end
      S_TRANS: begin
        // Pure rewiring: word (i,j) of the buffer lands at word (j,i) of out.
        for (int i = 0; i < row; i++) begin
          for (int j = 0; j < col; j++) begin
            out_d[(j*row+i)*W +: W] = buf_q[(i*col+j)*W +: W];
          end
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        // A request arriving together with output_taken is dropped on purpose.
        if (output_taken) state_d = S_IDLE;
      end
      default: begin
        // Unreachable encoding: recover to IDLE, leave out untouched.
        state_d = S_IDLE;
      end
    endcase
  end

  assign state = state_q;
  assign out   = out_q;

endmodule

// File: tb/tb_matrix_transposer.sv
module tb_matrix_transposer;

  localparam int W  = 20;
  localparam int NA = 8 * 8 * W;
  localparam int NB = 2 * 3 * W;

  typedef logic [NA-1:0] mat_a_t;
  typedef logic [NB-1:0] mat_b_t;

  typedef struct {
    mat_a_t in_m;
    mat_a_t exp_m;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8x8 instance
  logic       rst_a, ir_a, ot_a;
  mat_a_t     in_a, out_a;
  logic [1:0] st_a;

  // 2x3 instance
  logic       rst_b, ir_b, ot_b;
  mat_b_t     in_b, out_b;
  logic [1:0] st_b;

  matrix_transposer #(.IL(4), .FL(16), .row(8), .col(8)) dut_a (
    .clk(clk), .reset(rst_a), .input_ready(ir_a), .output_taken(ot_a),
    .in(in_a), .state(st_a), .out(out_a)
  );

  matrix_transposer #(.IL(4), .FL(16), .row(2), .col(3)) dut_b (
    .clk(clk), .reset(rst_b), .input_ready(ir_b), .output_taken(ot_b),
    .in(in_b), .state(st_b), .out(out_b)
  );

  int errs   = 0;
  int checks = 0;

  mat_a_t q_a[$];
  mat_b_t q_b[$];
  vec_t   tbl[4];

  task automatic chk_st(input string nm, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: state=%b required %b", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string nm, input mat_a_t act, input mat_a_t exp);
    int k;
    checks++;
    if (act !== exp) begin
      errs++;
      k = 0;
      while (k < 63 && act[k*W +: W] === exp[k*W +: W]) k++;
      $display("FAIL %s: word %0d got %h required %h", nm, k, act[k*W +: W], exp[k*W +: W]);
    end
  endtask

  task automatic chk_b(input string nm, input mat_b_t act, input mat_b_t exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: out=%h required %h", nm, act, exp);
    end
  endtask

  // Reference transpose, built by walking output words.
  function automatic mat_a_t model_t(input mat_a_t m);
    mat_a_t r;
    r = '0;
    for (int jj = 0; jj < 8; jj++)
      for (int ii = 0; ii < 8; ii++)
        r[(jj*8+ii)*W +: W] = m[(ii*8+jj)*W +: W];
    return r;
  endfunction

  function automatic mat_a_t rand_a();
    mat_a_t r;
    for (int k = 0; k < 64; k++) r[k*W +: W] = 20'($urandom);
    return r;
  endfunction

  // Called at a negedge: present request for one edge, return at the next negedge.
  task automatic req_a(input mat_a_t m);
    in_a = m;
    ir_a = 1'b1;
    @(negedge clk);
    ir_a = 1'b0;
  endtask

  task automatic wait_done_a(input string nm);
    int n = 0;
    while (st_a !== 2'b10 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk_st(nm, st_a, 2'b10);
  endtask

  task automatic take_a();
    ot_a = 1'b1;
    @(negedge clk);
    ot_a = 1'b0;
  endtask

  initial begin
    mat_a_t exp_m;
    mat_a_t r;
    mat_b_t eb;

    rst_a = 1'b0; ir_a = 1'b0; ot_a = 1'b0; in_a = '0;
    rst_b = 1'b0; ir_b = 1'b0; ot_b = 1'b0; in_b = '0;

    // Vector table
    for (int t = 0; t < 4; t++) begin
      tbl[t].in_m  = '0;
      tbl[t].exp_m = '0;
    end
    for (int p = 0; p < 8; p++)
      for (int q = 0; q < 8; q++) begin
        tbl[0].in_m[(p*8+q)*W +: W]  = 20'(p*8+q);
        tbl[0].exp_m[(q*8+p)*W +: W] = 20'(p*8+q);
      end
    tbl[1].in_m[(0*8+1)*W +: W]  = 20'hFFFFF;
    tbl[1].in_m[(2*8+3)*W +: W]  = 20'h80000;
    tbl[1].exp_m[(1*8+0)*W +: W] = 20'hFFFFF;
    tbl[1].exp_m[(3*8+2)*W +: W] = 20'h80000;
    tbl[2].in_m  = rand_a();
    tbl[2].exp_m = model_t(tbl[2].in_m);
    tbl[3].in_m  = '1;
    tbl[3].exp_m = '1;

    // Reset held with random inputs
    for (int c = 0; c < 2; c++) begin
      in_a = rand_a();
      ir_a = 1'($urandom_range(0, 1));
      ot_a = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk_st("reset_state", st_a, 2'b00);
    chk_a("reset_out", out_a, '0);
    ir_a = 1'b0; ot_a = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    chk_st("post_reset_idle", st_a, 2'b00);

    // Table-driven transposes
    for (int t = 0; t < 4; t++) begin
      q_a.push_back(tbl[t].exp_m);
      req_a(tbl[t].in_m);
      chk_st("tbl_transpose", st_a, 2'b01);
      @(negedge clk);
      wait_done_a("tbl_done");
      chk_a("tbl_out", out_a, q_a.pop_front());
      take_a();
      chk_st("tbl_idle", st_a, 2'b00);
    end

    // DONE holds while output_taken stays low
    r = rand_a();
    q_a.push_back(model_t(r));
    req_a(r);
    @(negedge clk);
    wait_done_a("hold_done");
    exp_m = q_a.pop_front();
    chk_a("hold_first", out_a, exp_m);
    for (int c = 0; c < 5; c++) begin
      in_a = rand_a();
      ir_a = 1'(c % 2 == 0);
      @(negedge clk);
      chk_st("hold_state", st_a, 2'b10);
      chk_a("hold_out", out_a, exp_m);
    end
    ir_a = 1'b0;
    take_a();
    chk_st("hold_release", st_a, 2'b00);
    chk_a("hold_retained", out_a, exp_m);

    // output_taken outside DONE does nothing
    ot_a = 1'b1;
    @(negedge clk);
    ot_a = 1'b0;
    chk_st("taken_in_idle", st_a, 2'b00);

    // Simultaneous request and take in DONE: request dropped
    r = rand_a();
    q_a.push_back(model_t(r));
    req_a(r);
    @(negedge clk);
    wait_done_a("sim_done");
    exp_m = q_a.pop_front();
    chk_a("sim_first", out_a, exp_m);
    r = rand_a();
    in_a = r;
    ir_a = 1'b1;
    ot_a = 1'b1;
    @(negedge clk);
    ir_a = 1'b0;
    ot_a = 1'b0;
    chk_st("sim_idle", st_a, 2'b00);
    @(negedge clk);
    chk_st("sim_no_capture", st_a, 2'b00);
    chk_a("sim_out_kept", out_a, exp_m);
    q_a.push_back(model_t(r));
    req_a(r);
    chk_st("rereq_transpose", st_a, 2'b01);
    @(negedge clk);
    chk_st("rereq_done", st_a, 2'b10);
    chk_a("rereq_out", out_a, q_a.pop_front());
    take_a();

    // Non-square 2x3
    for (int k = 0; k < 6; k++) in_b[k*W +: W] = 20'(k + 1);
    eb = {20'd6, 20'd3, 20'd5, 20'd2, 20'd4, 20'd1};
    q_b.push_back(eb);
    ir_b = 1'b1;
    @(negedge clk);
    ir_b = 1'b0;
    chk_st("ns_transpose", st_b, 2'b01);
    @(negedge clk);
    chk_st("ns_done", st_b, 2'b10);
    chk_b("ns_out", out_b, q_b.pop_front());
    ot_b = 1'b1;
    @(negedge clk);
    ot_b = 1'b0;
    chk_st("ns_idle", st_b, 2'b00);

    // Reset asserted during TRANSPOSE
    in_b = {6{20'h2A5A5}};
    ir_b = 1'b1;
    @(negedge clk);
    ir_b = 1'b0;
    chk_st("abort_busy", st_b, 2'b01);
    rst_b = 1'b0;
    #1;
    chk_st("abort_state", st_b, 2'b00);
    chk_b("abort_out", out_b, '0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk_st("abort_after", st_b, 2'b00);
    chk_b("abort_out_after", out_b, '0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
